trng_capture_buffer: RTL

- Parametrised multi-channel capture buffer for ring-oscillator entropy sources.
- Synchronises CHANNELS raw bits and stores one CHANNELS-bit word per sample into a DEPTH-entry RAM, with programmable decimation.
- Keeps per-channel ones counts for bias checks; an arm pulse from the debug core restarts a capture.
- Sits between the RO combiners and the ILA/VIO debug cores, and replaces the fixed single-channel capture register.

---
 rtl/trng_capture_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/trng_capture_buffer.sv
// Multi-channel ring-oscillator entropy capture buffer with decimation,
// per-channel ones counters and registered readout for debug cores.
//
// state     | meaning
// S_IDLE    | waiting for arm, no writes
// S_CAPTURE | sampling synchronised bits into RAM every decim+1 locked cycles
// S_DONE    | buffer full, counters and flags hold until arm
module trng_capture_buffer #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter int DECIM_W  = 8
) (
    input  logic                             clock,
    input  logic                             cpu_reset,
    input  logic                             locked,
    input  logic [CHANNELS-1:0]              raw_bits,
    input  logic                             arm,
    input  logic [DECIM_W-1:0]               decim,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic [CHANNELS-1:0]              rd_data,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_W:0]                  wr_count,
    output logic [CHANNELS*(ADDR_W+1)-1:0]   ones_count
);

    localparam int CW     = ADDR_W + 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0]      DEPTH_C  = CW'(DEPTH);
    localparam logic [DECIM_W-1:0] DCNT_ONE = DECIM_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state;
    logic [CHANNELS-1:0]  s1;
    logic [CHANNELS-1:0]  s2;
    logic [DECIM_W-1:0]   dcnt;
    logic [DECIM_W-1:0]   decim_reg;
    logic [CHANNELS-1:0]  mem [DEPTH];
    logic                 wr_en;

    // arm and reset both pre-empt a sample that would land in the same cycle
    assign wr_en = (state == S_CAPTURE) && locked && (dcnt == decim_reg)
                   && !arm && !cpu_reset;

    always_ff @(posedge clock) begin
        if (cpu_reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_bits;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_count[MEM_AW-1:0]] <= s2;
    end

    always_ff @(posedge clock) begin
        if (cpu_reset)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < DEPTH_C)
            rd_data <= mem[rd_addr[MEM_AW-1:0]];
        else
            rd_data <= '0;
    end

    always_ff @(posedge clock) begin
        if (cpu_reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_count   <= '0;
            ones_count <= '0;
            dcnt       <= '0;
            decim_reg  <= '0;
        end else if (arm) begin
            state      <= S_CAPTURE;
            busy       <= 1'b1;
            done       <= 1'b0;
            wr_count   <= '0;
            ones_count <= '0;
            dcnt       <= '0;
            decim_reg  <= decim;
        end else begin
            case (state)
                S_CAPTURE: begin
                    if (wr_en) begin
                        wr_count <= wr_count + CNT_ONE;
                        dcnt     <= '0;
                        for (int i = 0; i < CHANNELS; i++)
                            ones_count[i*CW +: CW] <= ones_count[i*CW +: CW] + CW'(s2[i]);
                        if (wr_count == LAST_IDX) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (locked) begin
                        dcnt <= dcnt + DCNT_ONE;
                    end
                end
                S_DONE:  state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
